// File: rtl/phy_rx_pkg.sv
// Shared phy serial-link definitions: receive FSM encoding and link symbols.
// Also the source of the COM/IDL defaults for the transmit-side serializer.
package phy_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]  COM_SYM   = 8'hBC;
    localparam logic [7:0]  IDL_SYM   = 8'h7C;
    localparam int unsigned N_COM_DEF = 4;

endpackage

// File: rtl/sym_detect.sv
// Link-symbol classifier for a candidate byte; purely combinational.
// No latency, no flow control.
module sym_detect
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM = COM_SYM,
    parameter logic [7:0] IDL = IDL_SYM
) (
    input  logic [7:0] candidate,
    output logic       is_com,
    output logic       is_idl
);

    assign is_com = (candidate == COM);
    assign is_idl = (candidate == IDL);

endmodule

// File: rtl/deserializador_sync.sv
// Serial-to-parallel receiver: hunts COM bitwise, locks after N_COM aligned COMs, emits data bytes.
// Outputs update on the edge sampling each byte's LSB and hold for the slot; no backpressure.
module deserializador_sync
    import phy_rx_pkg::*;
#(
    parameter logic [7:0]  COM   = COM_SYM,
    parameter logic [7:0]  IDL   = IDL_SYM,
    parameter int unsigned N_COM = N_COM_DEF
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [3:0] N_COM_L = 4'(N_COM);

    state_t     state;
    // Bit 7 of the shift register would never be read: the candidate already is the full byte.
    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic [3:0] com_cnt;
    logic [7:0] candidate;
    logic       is_com;
    logic       is_idl;
    logic       boundary;

    assign candidate = {shift, data_in};
    assign boundary  = (bit_cnt == 3'd7);

    sym_detect #(
        .COM (COM),
        .IDL (IDL)
    ) u_sym_detect (
        .candidate (candidate),
        .is_com    (is_com),
        .is_idl    (is_idl)
    );

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state     <= SEARCH;
            shift     <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            shift   <= candidate[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            case (state)
                SEARCH: begin
                    if (is_com) begin
                        bit_cnt <= 3'd0;
                        com_cnt <= 4'd1;
                        if (N_COM_L == 4'd1) begin
                            state  <= LOCKED;
                            active <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt <= com_cnt + 4'd1;
                            if (com_cnt + 4'd1 == N_COM_L) begin
                                state  <= LOCKED;
                                active <= 1'b1;
                            end
                        end else begin
                            // bit counter keeps wrapping; the hunt restarts on the next bit
                            com_cnt <= 4'd0;
                            state   <= SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        if (is_com || is_idl) begin
                            valid_out <= 1'b0;
                        end else begin
                            data_out  <= candidate;
                            valid_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deserializador_sync.sv
// Bench for deserializador_sync: directed scenarios plus random stream vs a bit-history reference model.
module tb_deserializador_sync;
    import phy_rx_pkg::*;

    localparam int N = 4;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_cmp = 0;
    int n_err = 0;

    deserializador_sync dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    // Reference model: full received bit history since reset; alignment tracked as the
    // bit time of the first COM of the current run, byte boundaries every 8 bits after it.
    bit         hist[$];
    int         t_now;
    int         anchor;
    int         run;
    bit         m_lock;
    logic [7:0] exp_data;
    bit         exp_vld;

    function automatic logic [7:0] last_byte();
        logic [7:0] w = '0;
        for (int i = 0; i < 8; i++) begin
            int idx = hist.size() - 8 + i;
            w = {w[6:0], (idx >= 0) ? hist[idx] : 1'b0};
        end
        return w;
    endfunction

    task automatic model_step(input logic b, input logic rst);
        logic [7:0] w;
        if (!rst) begin
            hist.delete();
            t_now    = 0;
            anchor   = -1;
            run      = 0;
            m_lock   = 1'b0;
            exp_data = 8'h00;
            exp_vld  = 1'b0;
            return;
        end
        hist.push_back(b);
        t_now++;
        w = last_byte();
        if (m_lock) begin
            if ((t_now - anchor) % 8 == 0) begin
                if (w != COM_SYM && w != IDL_SYM) begin
                    exp_data = w;
                    exp_vld  = 1'b1;
                end else begin
                    exp_vld = 1'b0;
                end
            end
        end else if (anchor < 0) begin
            if (w == COM_SYM) begin
                anchor = t_now;
                run    = 1;
                m_lock = (run == N);
            end
        end else if ((t_now - anchor) % 8 == 0) begin
            if (w == COM_SYM) begin
                run++;
                if (run == N) m_lock = 1'b1;
            end else begin
                anchor = -1;
                run    = 0;
            end
        end
    endtask

    task automatic tick(input logic b, input logic rst);
        data_in = b;
        reset   = rst;
        @(posedge clk_32f);
        model_step(b, rst);
        @(negedge clk_32f);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            tick(1'($urandom), 1'b0);
            n_cmp++;
            if ({active, valid_out, data_out} !== 10'h000) begin
                n_err++;
                $display("FAIL reset c%0d: got act=%b vld=%b dat=%h want act=0 vld=0 dat=00",
                         c, active, valid_out, data_out);
            end
        end
    endtask

    task automatic test_lock();
        logic [7:0] seq[$] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 8'h00};
        int bit_no = 0;
        int rise = -1;
        foreach (seq[k]) begin
            for (int i = 7; i >= 0; i--) begin
                tick(seq[k][i], 1'b1);
                n_cmp++;
                if ({active, valid_out, data_out} !== {m_lock, exp_vld, exp_data}) begin
                    n_err++;
                    $display("FAIL lock bit%0d: got act=%b vld=%b dat=%h want act=%b vld=%b dat=%h",
                             bit_no, active, valid_out, data_out, m_lock, exp_vld, exp_data);
                end
                if (active === 1'b1 && rise < 0) rise = bit_no;
                if (k == 4 && i == 0) begin
                    n_cmp++;
                    if (data_out !== 8'hA5 || valid_out !== 1'b1) begin
                        n_err++;
                        $display("FAIL lock_a5: got vld=%b dat=%h want vld=1 dat=a5", valid_out, data_out);
                    end
                end
                if (k == 5 && i > 0) begin
                    n_cmp++;
                    if (data_out !== 8'hA5 || valid_out !== 1'b1) begin
                        n_err++;
                        $display("FAIL lock_hold i%0d: got vld=%b dat=%h want vld=1 dat=a5", i, valid_out, data_out);
                    end
                end
                bit_no++;
            end
        end
        n_cmp++;
        if (rise !== 31) begin
            n_err++;
            $display("FAIL lock_edge: got active rise at bit %0d want 31", rise);
        end
    endtask

    task automatic test_misaligned();
        logic [7:0] seq[$] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h3C};
        tick(1'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'($urandom), 1'b1);
            n_cmp++;
            if ({active, valid_out, data_out} !== {m_lock, exp_vld, exp_data}) begin
                n_err++;
                $display("FAIL misal pre%0d: got act=%b vld=%b dat=%h want act=%b vld=%b dat=%h",
                         i, active, valid_out, data_out, m_lock, exp_vld, exp_data);
            end
        end
        foreach (seq[k]) begin
            for (int i = 7; i >= 0; i--) begin
                tick(seq[k][i], 1'b1);
                n_cmp++;
                if ({active, valid_out, data_out} !== {m_lock, exp_vld, exp_data}) begin
                    n_err++;
                    $display("FAIL misal byte%0d bit%0d: got act=%b vld=%b dat=%h want act=%b vld=%b dat=%h",
                             k, i, active, valid_out, data_out, m_lock, exp_vld, exp_data);
                end
            end
        end
        n_cmp++;
        if ({active, valid_out, data_out} !== {1'b1, 1'b1, 8'h3C}) begin
            n_err++;
            $display("FAIL misal_final: got act=%b vld=%b dat=%h want act=1 vld=1 dat=3c",
                     active, valid_out, data_out);
        end
    endtask

    task automatic test_broken_run();
        logic [7:0] seq[$] = '{8'hBC, 8'hBC, 8'h11, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h22};
        int n_vld = 0;
        tick(1'($urandom), 1'b0);
        foreach (seq[k]) begin
            for (int i = 7; i >= 0; i--) begin
                tick(seq[k][i], 1'b1);
                n_cmp++;
                if ({active, valid_out, data_out} !== {m_lock, exp_vld, exp_data}) begin
                    n_err++;
                    $display("FAIL broken byte%0d bit%0d: got act=%b vld=%b dat=%h want act=%b vld=%b dat=%h",
                             k, i, active, valid_out, data_out, m_lock, exp_vld, exp_data);
                end
                if (valid_out === 1'b1) n_vld++;
            end
            if (k == 2) begin
                n_cmp++;
                if (active !== 1'b0) begin
                    n_err++;
                    $display("FAIL broken_nolock: got act=%b want act=0", active);
                end
            end
        end
        n_cmp++;
        if (data_out !== 8'h22 || n_vld !== 1) begin
            n_err++;
            $display("FAIL broken_out: got dat=%h valid_cycles=%0d want dat=22 valid_cycles=1", data_out, n_vld);
        end
    endtask

    task automatic test_idle_com();
        logic [7:0] seq[4]  = '{8'h5A, 8'h7C, 8'hBC, 8'hFF};
        logic [7:0] want_d[4] = '{8'h5A, 8'h5A, 8'h5A, 8'hFF};
        bit         want_v[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            for (int i = 7; i >= 0; i--) begin
                tick(seq[k][i], 1'b1);
                n_cmp++;
                if ({active, valid_out, data_out} !== {m_lock, exp_vld, exp_data}) begin
                    n_err++;
                    $display("FAIL idle byte%0d bit%0d: got act=%b vld=%b dat=%h want act=%b vld=%b dat=%h",
                             k, i, active, valid_out, data_out, m_lock, exp_vld, exp_data);
                end
            end
            n_cmp++;
            if (valid_out !== want_v[k] || data_out !== want_d[k]) begin
                n_err++;
                $display("FAIL idle_slot%0d: got vld=%b dat=%h want vld=%b dat=%h",
                         k, valid_out, data_out, want_v[k], want_d[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d = 8'h96;
        logic [7:0] seq[$] = '{8'h96, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h69};
        for (int i = 7; i > 3; i--) tick(d[i], 1'b1);
        tick(d[3], 1'b0);
        n_cmp++;
        if ({active, valid_out, data_out} !== 10'h000) begin
            n_err++;
            $display("FAIL rstmid: got act=%b vld=%b dat=%h want act=0 vld=0 dat=00",
                     active, valid_out, data_out);
        end
        foreach (seq[k]) begin
            for (int i = 7; i >= 0; i--) begin
                tick(seq[k][i], 1'b1);
                n_cmp++;
                if ({active, valid_out, data_out} !== {m_lock, exp_vld, exp_data}) begin
                    n_err++;
                    $display("FAIL rstmid byte%0d bit%0d: got act=%b vld=%b dat=%h want act=%b vld=%b dat=%h",
                             k, i, active, valid_out, data_out, m_lock, exp_vld, exp_data);
                end
            end
            if (k == 3) begin
                n_cmp++;
                if (active !== 1'b0) begin
                    n_err++;
                    $display("FAIL rstmid_3com: got act=%b want act=0", active);
                end
            end
        end
        n_cmp++;
        if ({active, valid_out, data_out} !== {1'b1, 1'b1, 8'h69}) begin
            n_err++;
            $display("FAIL rstmid_relock: got act=%b vld=%b dat=%h want act=1 vld=1 dat=69",
                     active, valid_out, data_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        tick(1'($urandom), 1'b0);
        for (int item = 0; item < 80; item++) begin
            int r = $urandom_range(0, 9);
            int nbits = 8;
            int reps = 1;
            if (r < 3) begin
                b = COM_SYM;
                reps = $urandom_range(1, 5);
            end else if (r == 3) begin
                b = IDL_SYM;
            end else if (r == 4) begin
                b = 8'($urandom);
                nbits = $urandom_range(1, 7);
            end else begin
                b = 8'($urandom);
            end
            for (int rp = 0; rp < reps; rp++) begin
                for (int i = 7; i > 7 - nbits; i--) begin
                    tick(b[i], 1'b1);
                    n_cmp++;
                    if ({active, valid_out, data_out} !== {m_lock, exp_vld, exp_data}) begin
                        n_err++;
                        $display("FAIL random item%0d bit%0d: got act=%b vld=%b dat=%h want act=%b vld=%b dat=%h",
                                 item, i, active, valid_out, data_out, m_lock, exp_vld, exp_data);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_misaligned();
        test_broken_run();
        test_idle_com();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
